// File: rtl/booth_multiplier.sv
// booth_multiplier -- sequential radix-2 Booth multiplier with variable operand lengths.
//
// One Booth step is performed per clock for L_Q cycles after a start request.
// The multiplicand and multiplier are each truncated to their significant length
// and sign-extended from bit L-1. A length of 0 or above OP_WIDTH selects OP_WIDTH.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   inp                 start request, honoured only while idle
//   multiplicand        operand M (two's complement)
//   multiplicand_length significant bit count of M
//   multiplier          operand Q (two's complement)
//   multiplier_length   significant bit count of Q (also the step count)
//   product             signed result, 2*OP_WIDTH bits
//   add_count           number of Booth additions performed
//   sub_count           number of Booth subtractions performed
//   done                idle, ready to accept, and results valid
//
// Configuration macro: BOOTH_OPCOUNT_EN -- when defined, add_count/sub_count count
// Booth operations; when undefined they are tied to zero and the counters are absent.

module booth_multiplier #(
  parameter int OP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inp,
  input  logic [OP_WIDTH-1:0]     multiplicand,
  input  logic [4:0]              multiplicand_length,
  input  logic [OP_WIDTH-1:0]     multiplier,
  input  logic [4:0]              multiplier_length,
  output logic [2*OP_WIDTH-1:0]   product,
  output logic [4:0]              add_count,
  output logic [4:0]              sub_count,
  output logic                    done
);

  localparam int PW = 2 * OP_WIDTH + 1;
  localparam int LW = $clog2(OP_WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [LW-1:0] eff_len(input logic [4:0] len);
    if (len == 5'd0 || int'(len) > OP_WIDTH) return LW'(OP_WIDTH);
    else return LW'(len);
  endfunction

  logic [0:0]    state;
  logic [PW-1:0] p;        // accumulator/multiplier pair
  logic          q_prev;   // q_{i-1}
  logic [PW-1:0] msh;      // sign-extended M pre-aligned at bit L_Q
  logic [LW-1:0] lq_r;
  logic [LW-1:0] step;

  logic [LW-1:0] lm;
  logic [LW-1:0] lq;
  logic          msign;
  logic [PW-1:0] m_sext;
  logic [PW-1:0] m_shift;
  logic [PW-1:0] q_init;
  logic [1:0]    pair;
  logic [PW-1:0] sum;
  logic [PW-1:0] p_next;
  logic          last;

  // Operand normalisation for the accept cycle.
  always_comb begin
    lm     = eff_len(multiplicand_length);
    lq     = eff_len(multiplier_length);
    msign  = 1'b0;
    m_sext = '0;
    q_init = '0;
    for (int unsigned i = 0; i < OP_WIDTH; i++) begin
      if (i + 1 == 32'(lm)) msign = multiplicand[i];
    end
    for (int unsigned i = 0; i < OP_WIDTH; i++) begin
      m_sext[i] = (i < 32'(lm)) ? multiplicand[i] : msign;
      q_init[i] = (i < 32'(lq)) ? multiplier[i] : 1'b0;
    end
    for (int unsigned i = OP_WIDTH; i < PW; i++) begin
      m_sext[i] = msign;
    end
    // Adding M at bit L_Q lets the pair shift right exactly L_Q times and end
    // with the product aligned at bit 0, whatever the multiplier length.
    m_shift = m_sext << lq;
  end

  // One Booth step.
  always_comb begin
    pair = {p[0], q_prev};
    sum  = p;
    case (pair)
      2'b10:   sum = p - msh;
      2'b01:   sum = p + msh;
      default: sum = p;
    endcase
    p_next = PW'($signed(sum) >>> 1);
    last   = (step == lq_r - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      p       <= '0;
      q_prev  <= 1'b0;
      msh     <= '0;
      lq_r    <= '0;
      step    <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inp) begin
            msh     <= m_shift;
            p       <= q_init;
            q_prev  <= 1'b0;
            lq_r    <= lq;
            step    <= '0;
            product <= '0;
            state   <= RUN;
          end
        end
        default: begin
          p      <= p_next;
          q_prev <= p[0];
          step   <= step + 1'b1;
          if (last) begin
            product <= p_next[2*OP_WIDTH-1:0];
            state   <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef BOOTH_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      add_count <= '0;
      sub_count <= '0;
    end else if (state == IDLE) begin
      if (inp) begin
        add_count <= '0;
        sub_count <= '0;
      end
    end else begin
      if (pair == 2'b10) sub_count <= sub_count + 5'd1;
      if (pair == 2'b01) add_count <= add_count + 5'd1;
    end
  end
`else
  assign add_count = '0;
  assign sub_count = '0;
`endif

  assign done = (state == IDLE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: the driver pushes expected results computed
// from plain integer arithmetic; a monitor pops and compares each time done rises.
module tb_booth_multiplier;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           inp;
  logic [W-1:0]   multiplicand;
  logic [4:0]     multiplicand_length;
  logic [W-1:0]   multiplier;
  logic [4:0]     multiplier_length;
  logic [2*W-1:0] product;
  logic [4:0]     add_count;
  logic [4:0]     sub_count;
  logic           done;

  always #5 clk = ~clk;

  booth_multiplier #(.OP_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .inp(inp),
    .multiplicand(multiplicand),
    .multiplicand_length(multiplicand_length),
    .multiplier(multiplier),
    .multiplier_length(multiplier_length),
    .product(product),
    .add_count(add_count),
    .sub_count(sub_count),
    .done(done)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    int             adds;
    int             subs;
    int             lat;   // -1: aborted, latency not checked
    string          name;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  bit             mon_en = 1'b0;
  logic           prev_done = 1'b1;
  int             start_cyc = 0;
  logic [2*W-1:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff(input logic [4:0] l);
    return (l == 5'd0 || int'(l) > W) ? W : int'(l);
  endfunction

  function automatic longint sval(input logic [W-1:0] v, input int l);
    longint x = 0;
    for (int i = 0; i < l; i++) if (v[i]) x += longint'(1) << i;
    if (v[l-1]) x -= longint'(1) << l;
    return x;
  endfunction

  function automatic exp_t model(input logic [W-1:0] m, input logic [4:0] lm,
                                 input logic [W-1:0] q, input logic [4:0] lq,
                                 input string name);
    exp_t        e;
    int          l;
    longint      pr;
    logic [63:0] pv;
    logic        cur, prv;
    l  = eff(lq);
    pr = sval(m, eff(lm)) * sval(q, l);
    pv = pr;
    e.prod = pv[2*W-1:0];
    e.adds = 0;
    e.subs = 0;
    e.lat  = l;
    e.name = name;
`ifdef BOOTH_OPCOUNT_EN
    for (int i = 0; i < l; i++) begin
      cur = q[i];
      prv = (i == 0) ? 1'b0 : q[i-1];
      if (cur && !prv) e.subs++;
      if (!cur && prv) e.adds++;
    end
`endif
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (prev_done && !done) start_cyc = cyc;
      if (!prev_done && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got product %0h, expected no result", product);
        end else begin
          e = sb.pop_front();
          check({e.name, " product"}, product, e.prod);
          check({e.name, " add_count"}, add_count, e.adds);
          check({e.name, " sub_count"}, sub_count, e.subs);
          if (e.lat >= 0) check({e.name, " latency"}, cyc - start_cyc, e.lat);
          last_prod = e.prod;
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic set_ops(input logic [W-1:0] m, input logic [4:0] lm,
                         input logic [W-1:0] q, input logic [4:0] lq);
    multiplicand        = m;
    multiplicand_length = lm;
    multiplier          = q;
    multiplier_length   = lq;
  endtask

  task automatic issue(input logic [W-1:0] m, input logic [4:0] lm,
                       input logic [W-1:0] q, input logic [4:0] lq, input string name);
    @(negedge clk);
    set_ops(m, lm, q, lq);
    inp = 1'b1;
    sb.push_back(model(m, lm, q, lq, name));
    @(negedge clk);
    inp = 1'b0;
    wait_idle();
  endtask

  initial begin
    exp_t ab;
    rst = 1'b1;
    inp = 1'b0;
    set_ops('0, 5'd0, '0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset done", done, 1);
    check("reset product", product, 0);
    check("reset add_count", add_count, 0);
    check("reset sub_count", sub_count, 0);
    prev_done = done;
    mon_en = 1'b1;

    issue(16'd7, 5'd4, 16'd3, 5'd3, "unequal_len");
    issue(16'hFFFB, 5'd4, 16'd6, 5'd4, "neg_operand");
    issue(16'h0008, 5'd4, 16'h0008, 5'd4, "most_neg");
    issue(16'd12345, 5'd16, 16'd0, 5'd16, "zero_q");

    // Results hold while idle with inp low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold product", product, last_prod);
      check("hold done", done, 1);
    end

    // inp held high with operands changed during RUN.
    @(negedge clk);
    set_ops(16'd7, 5'd4, 16'd3, 5'd3);
    inp = 1'b1;
    sb.push_back(model(16'd7, 5'd4, 16'd3, 5'd3, "inp_held"));
    @(negedge clk);
    set_ops(16'd5, 5'd16, 16'd9, 5'd16);
    wait_idle();
    check("completing edge ignores inp", done, 1);
    sb.push_back(model(16'd5, 5'd16, 16'd9, 5'd16, "next_accept"));
    @(negedge clk);
    check("accept after done", done, 0);
    inp = 1'b0;
    wait_idle();

    // Abort in the 2nd RUN cycle.
    @(negedge clk);
    set_ops(16'hFFFB, 5'd4, 16'd6, 5'd4);
    inp = 1'b1;
    @(negedge clk);
    inp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ab.prod = '0;
    ab.adds = 0;
    ab.subs = 0;
    ab.lat  = -1;
    ab.name = "abort";
    sb.push_back(ab);
    @(negedge clk);
    rst = 1'b0;
    check("abort done", done, 1);
    issue(16'h0008, 5'd4, 16'h0008, 5'd4, "after_abort");

    // Randomized operands and lengths, including 0 and out-of-range lengths.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), 5'($urandom_range(0, 31)),
            W'($urandom), 5'($urandom_range(0, 31)), "random");
    end

    repeat (2) @(negedge clk);
    check("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have one parameter: OP_WIDTH, default 16, maximum operand width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port inp, input, 1 bit: start request.
REQ-006 Port multiplicand, input, OP_WIDTH bits: two's-complement operand M.
REQ-007 Port multiplicand_length, input, 5 bits: significant bit count L_M of M.
REQ-008 Port multiplier, input, OP_WIDTH bits: two's-complement operand Q.
REQ-009 Port multiplier_length, input, 5 bits: significant bit count L_Q of Q.
REQ-010 Port product, output, 2*OP_WIDTH bits: signed result.
REQ-011 Port add_count, output, 5 bits: number of Booth additions performed.
REQ-012 Port sub_count, output, 5 bits: number of Booth subtractions performed.
REQ-013 Port done, output, 1 bit: idle, ready to accept, and results valid.

Function
REQ-014 States SHALL be IDLE (done=1) and RUN (done=0).
REQ-015 In IDLE, inp=1 at a rising edge SHALL latch all four operand inputs, clear product, add_count, sub_count and the step counter, and enter RUN.
REQ-016 inp SHALL be ignored while in RUN, and the latched operands SHALL NOT change.
REQ-017 A length of 0 or greater than OP_WIDTH SHALL be treated as OP_WIDTH.
REQ-018 Bits at or above the length SHALL be ignored, and operands SHALL be sign-extended from bit L-1.
REQ-019 RUN SHALL perform exactly one radix-2 Booth step per cycle for L_Q cycles, examining the pair (q_i, q_{i-1}) with q_{-1}=0.
REQ-020 Pair 10 SHALL subtract M from the accumulator and increment sub_count.
REQ-021 Pair 01 SHALL add M to the accumulator and increment add_count.
REQ-022 Pairs 00 and 11 SHALL leave the accumulator and both counters unchanged.
REQ-023 Each step SHALL finish with an arithmetic right shift of the accumulator/multiplier pair.
REQ-024 Latency: for an accept at edge t0, done SHALL be 1 and product SHALL be final after edge t0+L_Q.
REQ-025 product SHALL equal the 2*OP_WIDTH-bit sign-extended value of M*Q.
REQ-026 In IDLE with inp=0, product, add_count and sub_count SHALL hold their values indefinitely.
REQ-027 inp=1 on the edge that completes RUN SHALL be ignored; the next accept SHALL occur no earlier than the following edge.
REQ-028 All arithmetic SHALL be performed at 2*OP_WIDTH+1 bits so that M = -2^(L_M-1) cannot overflow.

Reset
REQ-029 rst=1 at a rising edge SHALL set state to IDLE, done=1, product=0, add_count=0, sub_count=0 and the step counter to 0.
REQ-030 rst SHALL take priority over inp and over an in-progress RUN, and the aborted operation SHALL produce no result.

Configuration
REQ-031 With macro BOOTH_OPCOUNT_EN defined, add_count and sub_count SHALL behave per REQ-020 and REQ-021.
REQ-032 With BOOTH_OPCOUNT_EN undefined, add_count and sub_count SHALL be constant 0 and their counter logic SHALL be absent; all other behaviour is unchanged.

Verification (BOOTH_OPCOUNT_EN defined, OP_WIDTH=16)
REQ-033 Unequal lengths: M=7 (L_M=4), Q=3 (L_Q=3), inp pulse -> done low 3 cycles; product=21, add_count=1, sub_count=1.
REQ-034 Negative operand: M=-5 (4'b1011, L_M=4), Q=6 (L_Q=4) -> after 4 cycles product=32'hFFFFFFE2 (-30), add_count=1, sub_count=1.
REQ-035 Most-negative operands: M=-8 (L_M=4), Q=-8 (L_Q=4) -> product=64, add_count=0, sub_count=1.
REQ-036 Zero multiplier: Q=0 (L_Q=16), M=12345 -> done after 16 cycles; product=0, add_count=0, sub_count=0.
REQ-037 inp held high and operands changed during RUN of case REQ-033 -> result still 21, and a new accept occurs only on the edge after done rises.
REQ-038 rst asserted in the 2nd RUN cycle of case REQ-034 -> done=1, product=0, both counts 0 on the next edge; a following start of case REQ-035 yields 64.
